// File: rtl/lbp_pkg.sv
// Shared constants and types for the LBP engine and its histogram consumer.
package lbp_pkg;

    localparam int IMG_W = 128;
    localparam int IMG_H = 128;
    localparam int N_PIX = IMG_W * IMG_H;
    localparam int LBP_W = 8;
    localparam int N_BIN = 256;

    // Histogram block life cycle: accumulate a frame, stream it out, wait for finish to drop.
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DUMP  = 2'd1,
        DONE  = 2'd2
    } hist_state_t;

endpackage

// File: rtl/lbp_histogram.sv
// 256-bin histogram of LBP codes over one frame. After finish the bins are
// streamed out over valid/ready and cleared as they are read, so the array is
// already zero when the next frame starts accumulating.
module lbp_histogram #(
    parameter int N_PIX = 16384,
    parameter int CNT_W = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             lbp_valid,
    input  logic [13:0]      lbp_addr,
    input  logic [7:0]       lbp_data,
    input  logic             finish,
    input  logic             hist_ready,
    output logic             hist_valid,
    output logic [7:0]       hist_bin,
    output logic [CNT_W-1:0] hist_count,
    output logic             hist_done,
    output logic [CNT_W-1:0] pix_count,
    output logic             addr_err
);

    import lbp_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [13:0]      LAST_ADDR = 14'(N_PIX - 1);

    hist_state_t      r_state;
    hist_state_t      w_state_next;

    logic [CNT_W-1:0] r_bins [N_BIN];
    logic [CNT_W-1:0] r_pix_count;
    logic [CNT_W-1:0] w_pix_count_next;
    logic [7:0]       r_idx;
    logic [7:0]       w_idx_next;
    logic [7:0]       r_hist_bin;
    logic [7:0]       w_hist_bin_next;
    logic             r_hist_valid;
    logic             w_hist_valid_next;
    logic             r_hist_done;
    logic             w_hist_done_next;
    logic             r_addr_err;
    logic             w_addr_err_next;
    logic             r_seen_last;
    logic             w_seen_last_next;

    logic             w_accum_beat;
    logic             w_dump_accept;
    logic             w_last_accept;
    logic             w_start_dump;
    logic             w_restart;

    assign w_accum_beat  = (r_state == ACCUM) && lbp_valid;
    assign w_dump_accept = (r_state == DUMP) && r_hist_valid && hist_ready;
    assign w_last_accept = w_dump_accept && (r_idx == 8'hFF);
    assign w_start_dump  = (r_state == ACCUM) && finish;
    assign w_restart     = (r_state == DONE) && !finish;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DONE holds off a second dump while finish stays high.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM:   if (finish)        w_state_next = DUMP;
            DUMP:    if (w_last_accept) w_state_next = DONE;
            DONE:    if (!finish)       w_state_next = ACCUM;
            default:                    w_state_next = ACCUM;
        endcase
    end

    // Next values of the registered outputs and control counters.
    always_comb begin
        w_pix_count_next  = r_pix_count;
        w_idx_next        = r_idx;
        w_hist_bin_next   = r_hist_bin;
        w_hist_valid_next = r_hist_valid;
        w_hist_done_next  = r_hist_done;
        w_addr_err_next   = r_addr_err;
        w_seen_last_next  = r_seen_last;

        if (w_accum_beat) begin
            if (r_pix_count != CNT_MAX) begin
                w_pix_count_next = r_pix_count + 1'b1;
            end
            if (lbp_addr == LAST_ADDR) begin
                w_seen_last_next = 1'b1;
            end
        end

        if (w_start_dump) begin
            w_addr_err_next   = !r_seen_last;
            w_idx_next        = 8'd0;
            w_hist_valid_next = 1'b1;
            w_hist_bin_next   = 8'd0;
        end

        // idx and hist_bin wrap to 0 naturally after bin 255.
        if (w_dump_accept) begin
            w_idx_next      = r_idx + 8'd1;
            w_hist_bin_next = r_idx + 8'd1;
        end

        if (w_last_accept) begin
            w_hist_valid_next = 1'b0;
            w_hist_done_next  = 1'b1;
        end

        if (w_restart) begin
            w_pix_count_next = '0;
            w_seen_last_next = 1'b0;
            w_addr_err_next  = 1'b0;
            w_hist_done_next = 1'b0;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pix_count  <= '0;
            r_idx        <= 8'd0;
            r_hist_bin   <= 8'd0;
            r_hist_valid <= 1'b0;
            r_hist_done  <= 1'b0;
            r_addr_err   <= 1'b0;
            r_seen_last  <= 1'b0;
        end else begin
            r_pix_count  <= w_pix_count_next;
            r_idx        <= w_idx_next;
            r_hist_bin   <= w_hist_bin_next;
            r_hist_valid <= w_hist_valid_next;
            r_hist_done  <= w_hist_done_next;
            r_addr_err   <= w_addr_err_next;
            r_seen_last  <= w_seen_last_next;
        end
    end

    // Bin array: saturating increment while accumulating, clear-on-read while dumping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_BIN; i++) begin
                r_bins[i] <= '0;
            end
        end else begin
            if (w_accum_beat && (r_bins[lbp_data] != CNT_MAX)) begin
                r_bins[lbp_data] <= r_bins[lbp_data] + 1'b1;
            end
            if (w_dump_accept) begin
                r_bins[r_idx] <= '0;
            end
        end
    end

    assign hist_count = r_bins[r_idx];
    assign hist_valid = r_hist_valid;
    assign hist_bin   = r_hist_bin;
    assign hist_done  = r_hist_done;
    assign pix_count  = r_pix_count;
    assign addr_err   = r_addr_err;

endmodule

// File: tb/tb_lbp_histogram.sv
// Self-checking bench for lbp_histogram: random and golden LBP frames are
// histogrammed by a reference model and compared against the dumped bins.
module tb_lbp_histogram;

    localparam int CNT_W   = 15;
    localparam int NPIX    = 16384;
    localparam int CNT_SAT = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             lbp_valid;
    logic [13:0]      lbp_addr;
    logic [7:0]       lbp_data;
    logic             finish;
    logic             hist_ready;
    logic             hist_valid;
    logic [7:0]       hist_bin;
    logic [CNT_W-1:0] hist_count;
    logic             hist_done;
    logic [CNT_W-1:0] pix_count;
    logic             addr_err;

    always #5 clk = ~clk;

    lbp_histogram #(.N_PIX(NPIX), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_ready (hist_ready),
        .hist_valid (hist_valid),
        .hist_bin   (hist_bin),
        .hist_count (hist_count),
        .hist_done  (hist_done),
        .pix_count  (pix_count),
        .addr_err   (addr_err)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    int   ref_hist [256];
    int   ref_pix;
    bit   ref_seen;
    logic [7:0] img  [NPIX];
    logic [7:0] gold [NPIX];

    task automatic check_value(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) ref_hist[i] = 0;
        ref_pix  = 0;
        ref_seen = 0;
    endtask

    // Drive one LBP beat for the coming rising edge and record it in the model.
    task automatic beat(input logic [7:0] code, input logic [13:0] addr);
        lbp_valid = 1'b1;
        lbp_data  = code;
        lbp_addr  = addr;
        if (ref_hist[code] < CNT_SAT) ref_hist[code]++;
        if (ref_pix < CNT_SAT) ref_pix++;
        if (int'(addr) == NPIX - 1) ref_seen = 1;
    endtask

    // Build a random image and its 3x3 LBP codes; border pixels carry code 0.
    task automatic make_golden();
        for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
        for (int y = 0; y < 128; y++) begin
            for (int x = 0; x < 128; x++) begin
                logic [7:0] c;
                int dy[8] = '{-1, -1, -1, 0, 1, 1, 1, 0};
                int dx[8] = '{-1, 0, 1, 1, 1, 0, -1, -1};
                c = 8'd0;
                if (y > 0 && y < 127 && x > 0 && x < 127) begin
                    for (int k = 0; k < 8; k++) begin
                        if (img[(y + dy[k]) * 128 + x + dx[k]] >= img[y * 128 + x]) c[7 - k] = 1'b1;
                    end
                end
                gold[y * 128 + x] = c;
            end
        end
    endtask

    // Consume the dump with the given ready duty; stop_after >= 0 abandons it after that many beats.
    task automatic run_dump(input string name, input int ready_pct, input bit chk_timing, input int stop_after);
        int         exp_idx = 0;
        int         cyc = 0;
        int         done_cyc = 0;
        int         sum = 0;
        bit         stalled = 0;
        logic [7:0] sb = 8'd0;
        int         sc = 0;
        int         exp_err;
        exp_err = ref_seen ? 0 : 1;
        while (cyc < 3000) begin
            @(negedge clk);
            cyc++;
            lbp_valid = ($urandom_range(0, 1) == 1);
            lbp_data  = 8'($urandom);
            lbp_addr  = 14'($urandom);
            if (hist_done) begin
                done_cyc = cyc;
                break;
            end
            if (!hist_valid) begin
                check_value({name, "_valid_in_dump"}, 0, 1);
                break;
            end
            if (stalled) begin
                check_value({name, "_stall_bin"}, int'(hist_bin), int'(sb));
                check_value({name, "_stall_count"}, int'(hist_count), sc);
            end
            if (cyc == 1) check_value({name, "_addr_err_dump"}, int'(addr_err), exp_err);
            if (exp_idx == stop_after) break;
            if ($urandom_range(1, 100) <= ready_pct) begin
                hist_ready = 1'b1;
                check_value({name, "_bin_idx"}, int'(hist_bin), exp_idx);
                check_value({name, $sformatf("_bin%0d_count", exp_idx)}, int'(hist_count), ref_hist[exp_idx]);
                sum += int'(hist_count);
                exp_idx++;
                stalled = 0;
            end else begin
                hist_ready = 1'b0;
                stalled = 1;
                sb = hist_bin;
                sc = int'(hist_count);
            end
        end
        hist_ready = 1'b0;
        lbp_valid  = 1'b0;
        if (stop_after < 0) begin
            check_value({name, "_beats_accepted"}, exp_idx, 256);
            check_value({name, "_hist_done"}, int'(hist_done), 1);
            check_value({name, "_valid_after_done"}, int'(hist_valid), 0);
            check_value({name, "_count_sum"}, sum, ref_pix);
            check_value({name, "_pix_count_done"}, int'(pix_count), ref_pix);
            check_value({name, "_addr_err_done"}, int'(addr_err), exp_err);
            if (chk_timing) check_value({name, "_done_latency"}, done_cyc, 257);
            $display("[TB] %s: dump of %0d beats, done at cycle %0d", name, exp_idx, done_cyc);
        end
    endtask

    // Hold finish in DONE (no second dump may start), then drop it and check the restart.
    task automatic release_finish(input string name, input int hold);
        int saw_valid = 0;
        int lost_done = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (hist_valid) saw_valid++;
            if (!hist_done) lost_done++;
        end
        check_value({name, "_no_second_dump"}, saw_valid, 0);
        check_value({name, "_done_held"}, lost_done, 0);
        finish = 1'b0;
        @(negedge clk);
        check_value({name, "_done_cleared"}, int'(hist_done), 0);
        check_value({name, "_pix_cleared"}, int'(pix_count), 0);
        check_value({name, "_addr_err_cleared"}, int'(addr_err), 0);
        model_clear();
    endtask

    task automatic end_frame();
        @(negedge clk);
        lbp_valid = 1'b0;
        @(negedge clk);
        check_value("pix_count_accum", int'(pix_count), ref_pix);
        finish = 1'b1;
    endtask

    initial begin
        reset      = 1'b0;
        lbp_valid  = 1'b0;
        lbp_addr   = 14'd0;
        lbp_data   = 8'd0;
        finish     = 1'b0;
        hist_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check_value("rst_hist_valid", int'(hist_valid), 0);
        check_value("rst_hist_bin", int'(hist_bin), 0);
        check_value("rst_hist_done", int'(hist_done), 0);
        check_value("rst_pix_count", int'(pix_count), 0);
        check_value("rst_addr_err", int'(addr_err), 0);
        check_value("rst_hist_count", int'(hist_count), 0);
        reset = 1'b1;

        // Full frame of code 0x00, ready held high.
        for (int i = 0; i < NPIX; i++) begin
            @(negedge clk);
            beat(8'h00, 14'(i));
        end
        end_frame();
        run_dump("zero_frame", 100, 1, -1);
        release_finish("zero_frame", 20);

        // Back-to-back same-code beats, finish together with the last beat.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            beat((i < 3) ? 8'h5A : 8'hFF, 14'($urandom_range(0, NPIX - 2)));
            if (i == 3) finish = 1'b1;
        end
        run_dump("b2b", 100, 0, -1);
        check_value("b2b_model_5a", ref_hist[8'h5A], 3);
        release_finish("b2b", 5);

        // Second small frame after a held finish: proves clear-on-read.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            beat(8'h11, 14'(i));
        end
        end_frame();
        run_dump("frame_0x11", 100, 0, -1);
        release_finish("frame_0x11", 10);

        // Reset in the middle of accumulation.
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            beat(8'($urandom), 14'(i));
        end
        @(negedge clk);
        lbp_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_value("rst_accum_pix", int'(pix_count), 0);
        check_value("rst_accum_count", int'(hist_count), 0);
        check_value("rst_accum_valid", int'(hist_valid), 0);
        @(negedge clk);
        reset = 1'b1;
        model_clear();

        // Reset in the middle of a dump, at bin 100.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            beat(8'($urandom), 14'(i));
        end
        end_frame();
        run_dump("mid_dump", 100, 0, 100);
        check_value("mid_dump_bin", int'(hist_bin), 100);
        finish = 1'b0;
        reset = 1'b0;
        #1;
        check_value("rst_dump_valid", int'(hist_valid), 0);
        check_value("rst_dump_bin", int'(hist_bin), 0);
        check_value("rst_dump_pix", int'(pix_count), 0);
        check_value("rst_dump_addr_err", int'(addr_err), 0);
        check_value("rst_dump_done", int'(hist_done), 0);
        @(negedge clk);
        reset = 1'b1;
        model_clear();

        // Golden LBP frame with ~30% ready duty.
        make_golden();
        for (int i = 0; i < NPIX; i++) begin
            @(negedge clk);
            beat(gold[i], 14'(i));
        end
        end_frame();
        run_dump("golden", 30, 0, -1);
        release_finish("golden", 5);

        // Short frame missing the last address: addr_err expected.
        for (int i = 0; i < 16000; i++) begin
            @(negedge clk);
            beat(8'($urandom), 14'(i));
        end
        end_frame();
        run_dump("short_frame", 100, 0, -1);
        check_value("short_addr_err_model", ref_seen ? 1 : 0, 0);
        release_finish("short_frame", 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
